hazard_unit: RTL and testbench



---
 rtl/hazard_unit_pkg.sv | 13 +
 rtl/hazard_sat_counter.sv | 22 ++
 rtl/hazard_unit.sv | 83 ++++++++
 tb/tb_hazard_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline constants for the hazard/forwarding logic: register index
// width, the architectural zero register and the EXEC forwarding select encoding.
package hazard_unit_pkg;

   localparam int REG_IDX_W = 5;

   localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/hazard_sat_counter.sv
// Event counter that increments on each enabled cycle and sticks at all-ones
// rather than wrapping, so a long-running monitor never reports a small count.
module hazard_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + CNT_ONE;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the FETCH/EXEC/MEM/WB pipeline.
// All hazard outputs are combinational; only the two performance counters are clocked.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 MEM_rd_reg_write,
   input  logic                 WB_rd_reg_write,
   input  logic [REG_IDX_W-1:0] EXEC_rs1,
   input  logic [REG_IDX_W-1:0] EXEC_rs2,
   input  logic [REG_IDX_W-1:0] MEM_rd,
   input  logic [REG_IDX_W-1:0] WB_rd,
   input  logic [REG_IDX_W-1:0] WB_rd_skid,
   input  logic [REG_IDX_W-1:0] FETCH_rs1,
   input  logic [REG_IDX_W-1:0] FETCH_rs2,
   input  logic [REG_IDX_W-1:0] EXEC_rd,
   input  logic                 EXEC_mem2reg,
   input  logic                 BRA,
   input  logic                 JMP,
   input  logic                 FETCH_valid,
   input  logic                 MEM_valid,
   output logic [1:0]           FWD_rs1,
   output logic [1:0]           FWD_rs2,
   output logic                 FWD_rs1_fetch,
   output logic                 FWD_rs2_fetch,
   output logic                 FETCH_stall,
   output logic                 EXEC_stall,
   output logic                 EXEC_flush,
   output logic                 MEM_flush,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   logic mem_hit_rs1, mem_hit_rs2;
   logic wb_hit_rs1, wb_hit_rs2;
   logic redirect, load_stall;

   assign mem_hit_rs1 = MEM_rd_reg_write && (MEM_rd != ZERO_REG) && (EXEC_rs1 == MEM_rd);
   assign mem_hit_rs2 = MEM_rd_reg_write && (MEM_rd != ZERO_REG) && (EXEC_rs2 == MEM_rd);
   assign wb_hit_rs1  = WB_rd_reg_write && (WB_rd != ZERO_REG) && (EXEC_rs1 == WB_rd);
   assign wb_hit_rs2  = WB_rd_reg_write && (WB_rd != ZERO_REG) && (EXEC_rs2 == WB_rd);

   // MEM holds the younger producer, so it takes priority over WB.
   always_comb begin
      FWD_rs1 = FWD_NONE;
      FWD_rs2 = FWD_NONE;
      if (mem_hit_rs1)     FWD_rs1 = FWD_MEM;
      else if (wb_hit_rs1) FWD_rs1 = FWD_WB;
      if (mem_hit_rs2)     FWD_rs2 = FWD_MEM;
      else if (wb_hit_rs2) FWD_rs2 = FWD_WB;
   end

   assign FWD_rs1_fetch = WB_rd_reg_write && (WB_rd_skid != ZERO_REG) && (FETCH_rs1 == WB_rd_skid);
   assign FWD_rs2_fetch = WB_rd_reg_write && (WB_rd_skid != ZERO_REG) && (FETCH_rs2 == WB_rd_skid);

   assign redirect   = MEM_valid && (BRA || JMP);
   assign load_stall = FETCH_valid && EXEC_mem2reg && (EXEC_rd != ZERO_REG) &&
                       ((FETCH_rs1 == EXEC_rd) || (FETCH_rs2 == EXEC_rd));

   // A redirect makes the FETCH instruction wrong-path, so stalling it is pointless.
   assign FETCH_stall = load_stall && !redirect;
   assign EXEC_stall  = load_stall && !redirect;
   assign EXEC_flush  = redirect || load_stall;
   assign MEM_flush   = redirect;

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (FETCH_stall),
      .count (stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (MEM_flush),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a reference model predicts the combinational
// outputs and the saturating counters for every stimulus cycle.
module tb_hazard_unit;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             clk;
   logic             rst_n;
   logic             MEM_rd_reg_write, WB_rd_reg_write;
   logic [4:0]       EXEC_rs1, EXEC_rs2, MEM_rd, WB_rd, WB_rd_skid;
   logic [4:0]       FETCH_rs1, FETCH_rs2, EXEC_rd;
   logic             EXEC_mem2reg, BRA, JMP, FETCH_valid, MEM_valid;
   logic [1:0]       FWD_rs1, FWD_rs2;
   logic             FWD_rs1_fetch, FWD_rs2_fetch;
   logic             FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   logic [9:0]       exp_q[$];
   logic [CNT_W-1:0] m_stall_cnt, m_flush_cnt;
   int               n_checks, n_fail;

   hazard_unit #(.CNT_W(CNT_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .MEM_rd_reg_write (MEM_rd_reg_write),
      .WB_rd_reg_write  (WB_rd_reg_write),
      .EXEC_rs1         (EXEC_rs1),
      .EXEC_rs2         (EXEC_rs2),
      .MEM_rd           (MEM_rd),
      .WB_rd            (WB_rd),
      .WB_rd_skid       (WB_rd_skid),
      .FETCH_rs1        (FETCH_rs1),
      .FETCH_rs2        (FETCH_rs2),
      .EXEC_rd          (EXEC_rd),
      .EXEC_mem2reg     (EXEC_mem2reg),
      .BRA              (BRA),
      .JMP              (JMP),
      .FETCH_valid      (FETCH_valid),
      .MEM_valid        (MEM_valid),
      .FWD_rs1          (FWD_rs1),
      .FWD_rs2          (FWD_rs2),
      .FWD_rs1_fetch    (FWD_rs1_fetch),
      .FWD_rs2_fetch    (FWD_rs2_fetch),
      .FETCH_stall      (FETCH_stall),
      .EXEC_stall       (EXEC_stall),
      .EXEC_flush       (EXEC_flush),
      .MEM_flush        (MEM_flush),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // reference model
   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (MEM_rd_reg_write && MEM_rd != 5'd0 && rs == MEM_rd) return 2'b01;
      if (WB_rd_reg_write && WB_rd != 5'd0 && rs == WB_rd)     return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [9:0] ref_model();
      logic lu, rd, f1, f2;
      rd = MEM_valid && (BRA || JMP);
      lu = FETCH_valid && EXEC_mem2reg && EXEC_rd != 5'd0 &&
           (FETCH_rs1 == EXEC_rd || FETCH_rs2 == EXEC_rd);
      f1 = WB_rd_reg_write && WB_rd_skid != 5'd0 && FETCH_rs1 == WB_rd_skid;
      f2 = WB_rd_reg_write && WB_rd_skid != 5'd0 && FETCH_rs2 == WB_rd_skid;
      return {ref_fwd(EXEC_rs1), ref_fwd(EXEC_rs2), f1, f2,
              lu && !rd, lu && !rd, lu || rd, rd};
   endfunction

   // driver tasks
   task automatic idle();
      MEM_rd_reg_write = 0; WB_rd_reg_write = 0;
      EXEC_rs1 = 0; EXEC_rs2 = 0; MEM_rd = 0; WB_rd = 0; WB_rd_skid = 0;
      FETCH_rs1 = 0; FETCH_rs2 = 0; EXEC_rd = 0;
      EXEC_mem2reg = 0; BRA = 0; JMP = 0; FETCH_valid = 0; MEM_valid = 0;
   endtask

   // Inputs are set between edges; compare combinational outputs, then counters after the edge.
   task automatic step(input string tag);
      logic [9:0] e, got;
      e = ref_model();
      exp_q.push_back(e);
      #1;
      got = {FWD_rs1, FWD_rs2, FWD_rs1_fetch, FWD_rs2_fetch,
             FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush};
      check({tag, "_comb"}, {22'd0, got}, {22'd0, exp_q.pop_front()});
      @(posedge clk);
      if (rst_n) begin
         if (e[3] && m_stall_cnt != CNT_MAX) m_stall_cnt = m_stall_cnt + 1'b1;
         if (e[0] && m_flush_cnt != CNT_MAX) m_flush_cnt = m_flush_cnt + 1'b1;
      end
      #1;
      check({tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, m_stall_cnt});
      check({tag, "_flush_cnt"}, {28'd0, flush_cnt}, {28'd0, m_flush_cnt});
   endtask

   task automatic set_load_use();
      idle();
      FETCH_valid = 1; EXEC_mem2reg = 1; EXEC_rd = 5'd3; FETCH_rs1 = 5'd3;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      m_stall_cnt = '0; m_flush_cnt = '0;
      idle();
      rst_n = 1'b0;
      #3;
      check("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      check("reset_flush_cnt", {28'd0, flush_cnt}, 32'd0);
      step("in_reset");
      #2 rst_n = 1'b1;

      // EXEC forwarding, MEM over WB, then WB alone
      idle(); EXEC_rs1 = 5; MEM_rd = 5; WB_rd = 5; MEM_rd_reg_write = 1; WB_rd_reg_write = 1;
      step("fwd_mem_prio");
      check("fwd_rs1_mem", {30'd0, FWD_rs1}, 32'h1);
      MEM_rd_reg_write = 0;
      step("fwd_wb");
      check("fwd_rs1_wb", {30'd0, FWD_rs1}, 32'h2);

      // x0 is never forwarded
      idle(); EXEC_rs2 = 0; MEM_rd = 0; MEM_rd_reg_write = 1;
      FETCH_rs1 = 0; WB_rd_skid = 0; WB_rd_reg_write = 1;
      step("x0_no_fwd");
      check("fwd_rs2_x0", {30'd0, FWD_rs2}, 32'h0);
      check("fwd_rs1_fetch_x0", {31'd0, FWD_rs1_fetch}, 32'h0);

      // FETCH read-during-write bypass
      idle(); FETCH_rs2 = 7; WB_rd_skid = 7; WB_rd_reg_write = 1;
      step("fetch_byp");
      check("fwd_rs2_fetch_on", {31'd0, FWD_rs2_fetch}, 32'h1);
      WB_rd_reg_write = 0;
      step("fetch_byp_off");
      check("fwd_rs2_fetch_off", {31'd0, FWD_rs2_fetch}, 32'h0);

      // load-use stall, counting once per held cycle
      set_load_use();
      repeat (3) step("load_use");
      check("stall_cnt_3", {28'd0, stall_cnt}, 32'd3);
      check("load_use_flags", {28'd0, FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush}, 32'hE);

      // redirect overrides the stall; an invalid MEM redirect does nothing
      MEM_valid = 1; JMP = 1;
      repeat (2) step("jmp_over_stall");
      check("jmp_flags", {28'd0, FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush}, 32'h3);
      check("flush_cnt_2", {28'd0, flush_cnt}, 32'd2);
      idle(); MEM_valid = 0; BRA = 1;
      step("bra_invalid");
      check("bra_invalid_flush", {31'd0, MEM_flush}, 32'h0);
      idle(); FETCH_valid = 1; EXEC_mem2reg = 1; EXEC_rd = 0; FETCH_rs1 = 0;
      step("load_x0");

      // randomised mix over a small register range to provoke hits
      for (int i = 0; i < 150; i++) begin
         MEM_rd_reg_write = 1'($urandom_range(0, 1));
         WB_rd_reg_write  = 1'($urandom_range(0, 1));
         EXEC_rs1   = 5'($urandom_range(0, 3));
         EXEC_rs2   = 5'($urandom_range(0, 3));
         MEM_rd     = 5'($urandom_range(0, 3));
         WB_rd      = 5'($urandom_range(0, 3));
         WB_rd_skid = 5'($urandom_range(0, 3));
         FETCH_rs1  = 5'($urandom_range(0, 3));
         FETCH_rs2  = 5'($urandom_range(0, 3));
         EXEC_rd    = 5'($urandom_range(0, 3));
         EXEC_mem2reg = 1'($urandom_range(0, 1));
         BRA        = 1'($urandom_range(0, 3) == 0);
         JMP        = 1'($urandom_range(0, 3) == 0);
         FETCH_valid = 1'($urandom_range(0, 1));
         MEM_valid  = 1'($urandom_range(0, 1));
         step("rand");
      end

      // asynchronous reset mid-count clears counters, not the hazard outputs
      set_load_use();
      step("pre_reset");
      #2 rst_n = 1'b0;
      #1;
      m_stall_cnt = '0; m_flush_cnt = '0;
      check("async_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      check("async_rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
      step("during_reset");
      #2 rst_n = 1'b1;

      // saturation at all-ones
      set_load_use();
      repeat (20) step("stall_sat");
      check("stall_cnt_sat", {28'd0, stall_cnt}, 32'hF);
      idle(); MEM_valid = 1; BRA = 1;
      repeat (20) step("flush_sat");
      check("flush_cnt_sat", {28'd0, flush_cnt}, 32'hF);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
